// File: rtl/counter_sched.sv
// counter_sched: round-robin arbiter sharing one up-counter among N_REQ timed-interval requesters
module counter_sched #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] dur,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [WIDTH-1:0]       count,
  output logic                   busy
);
  localparam int PW = $clog2(N_REQ);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0]       state;
  logic [PW-1:0]    ptr, owner, win, idx;
  logic [WIDTH-1:0] ldur;
  logic [WIDTH-1:0] dur_a [N_REQ];
  for (genvar i = 0; i < N_REQ; i++) begin : g_dur
    assign dur_a[i] = dur[i*WIDTH +: WIDTH];
  end
  // descending scan so the requester closest to ptr is the last (winning) assignment
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N_REQ);
      if (req[idx]) win = idx;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      done  <= '0;
      count <= '0;
      busy  <= 1'b0;
      ptr   <= '0;
      owner <= '0;
      ldur  <= '0;
    end else if (state == IDLE) begin
      if (|req) begin
        state      <= RUN;
        gnt        <= '0;
        gnt[win]   <= 1'b1;
        count      <= '0;
        busy       <= 1'b1;
        ldur       <= dur_a[win];
        owner      <= win;
        ptr        <= (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
      end
    end else if (state == RUN) begin
      if (!req[owner]) begin
        state <= IDLE;
        gnt   <= '0;
        busy  <= 1'b0;
      end else if (count == ldur - 1'b1) begin
        state       <= DONE;
        gnt         <= '0;
        done[owner] <= 1'b1;
      end else begin
        count <= count + 1'b1;
      end
    end else begin
      state <= IDLE;
      done  <= '0;
      busy  <= 1'b0;
    end
  end
endmodule
